// File: rtl/ltica_pkg.sv
// Shared lamp-table definitions: pattern/index widths, special codes, and the
// index<->pattern mapping used by both the LED table and its decoder.
package ltica_pkg;

  localparam int PAT_W = 6;
  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] CODE_ALL = 3'd6;
  localparam logic [IDX_W-1:0] CODE_BAD = 3'd7;

  // Index to lamp pattern: 0..5 one-hot, CODE_ALL lights every lamp.
  function automatic logic [PAT_W-1:0] pat_of(input logic [IDX_W-1:0] idx);
    logic [PAT_W-1:0] pat;
    pat = '0;
    if (32'(idx) < PAT_W) pat = PAT_W'(1) << idx;
    else if (idx == CODE_ALL) pat = '1;
    return pat;
  endfunction

  function automatic logic [IDX_W-1:0] encode_pat(input logic [PAT_W-1:0] pattern);
    logic [IDX_W-1:0] idx;
    idx = CODE_BAD;
    if (pattern == '1) begin
      idx = CODE_ALL;
    end else begin
      for (int k = 0; k < PAT_W; k++) begin
        if (pattern == pat_of(IDX_W'(k))) idx = IDX_W'(k);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/lsync_debounce.sv
// Two-flop synchroniser plus debounce counter; emits a one-cycle strobe when a
// new nonzero pattern has been stable for DEBOUNCE cycles.
module lsync_debounce
  import ltica_pkg::*;
#(
  parameter int DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAT_W-1:0] din,
  output logic [PAT_W-1:0] accepted,
  output logic             strobe
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic [PAT_W-1:0] sync1;
  logic [PAT_W-1:0] s;
  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             stb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      s     <= '0;
      cand  <= '0;
      acc   <= '0;
      cnt   <= '0;
      stb   <= 1'b0;
    end else begin
      sync1 <= din;
      s     <= sync1;
      stb   <= 1'b0;
      if (s != cand) begin
        cand <= s;
        cnt  <= CNT_W'(1);
      end else begin
        if (cnt < CNT_W'(DEBOUNCE)) cnt <= cnt + CNT_W'(1);
        // A settled release (all zero) is absorbed without an event.
        if (cnt == CNT_W'(DEBOUNCE) && cand != acc) begin
          acc <= cand;
          stb <= (cand != '0);
        end
      end
    end
  end

  assign accepted = acc;
  assign strobe   = stb;

endmodule

// File: rtl/ldecode.sv
// Lamp-pattern decoder: debounced pattern -> 3-bit index, delivered through an
// output register backed by a one-deep pending slot.
module ldecode
  import ltica_pkg::*;
#(
  parameter int DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAT_W-1:0] tvalue_in,
  output logic [IDX_W-1:0] nowCount,
  output logic             valid,
  input  logic             ready,
  output logic             overflow,
  input  logic             clear_ovf
);

  logic [PAT_W-1:0] accepted;
  logic             strobe;
  logic [IDX_W-1:0] new_idx;

  lsync_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (tvalue_in),
    .accepted (accepted),
    .strobe   (strobe)
  );

  assign new_idx = encode_pat(accepted);

  // Handshake: nowCount transfers on any rising edge where valid && ready;
  // while valid is high and ready is low, nowCount and valid hold steady.
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W-1:0] pend_idx;
  logic             out_v;
  logic             pend_v;
  logic             ovf;
  logic             take;

  assign take = out_v && ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_idx  <= '0;
      pend_idx <= '0;
      out_v    <= 1'b0;
      pend_v   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (strobe) begin
        if (!out_v) begin
          out_idx <= new_idx;
          out_v   <= 1'b1;
        end else if (take) begin
          if (pend_v) begin
            out_idx  <= pend_idx;
            pend_idx <= new_idx;
          end else begin
            out_idx <= new_idx;
          end
        end else begin
          // Both slots busy: newest index wins, the older pending one is lost.
          pend_idx <= new_idx;
          pend_v   <= 1'b1;
        end
      end else if (take) begin
        if (pend_v) begin
          out_idx <= pend_idx;
          pend_v  <= 1'b0;
        end else begin
          out_v <= 1'b0;
        end
      end

      if (strobe && out_v && !take && pend_v) ovf <= 1'b1;
      else if (clear_ovf) ovf <= 1'b0;
    end
  end

  assign nowCount = out_idx;
  assign valid    = out_v;
  assign overflow = ovf;

endmodule

// File: tb/tb_ldecode.sv
// Bench for ldecode: directed scenarios plus randomized pattern holds and glitches,
// scored against a pattern-level model of which indices should be delivered.
module tb_ldecode;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] tvalue_in;
  logic [2:0] nowCount;
  logic       valid;
  logic       ready;
  logic       overflow;
  logic       clear_ovf;

  ldecode #(.DEBOUNCE(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tvalue_in (tvalue_in),
    .nowCount  (nowCount),
    .valid     (valid),
    .ready     (ready),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  int xfers    = 0;
  int stall    = 0;
  bit rnd_ready = 1'b0;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference decode, straight from the lamp table's meaning.
  function automatic logic [2:0] ref_index(input logic [5:0] p);
    if (p == 6'h3f) return 3'd6;
    if ($countones(p) == 1) begin
      for (int k = 0; k < 6; k++) if (p[k]) return 3'(k);
    end
    return 3'd7;
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_ready) begin
        if (stall >= 2) ready = 1'b1;
        else ready = 1'($urandom_range(0, 1));
        stall = ready ? 0 : stall + 1;
      end
    end
  endtask

  task automatic hold(input logic [5:0] p, input int n);
    tvalue_in = p;
    tick(n);
  endtask

  // scoreboard: inputs are stable between negedge and the next posedge
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) check("xfer_unexpected", 8'(nowCount), 8'hff);
      else check("xfer_index", 8'(nowCount), 8'(exp_q.pop_front()));
      xfers++;
    end
  end

  initial begin
    int base;
    logic [5:0] last_acc;
    logic [5:0] held;
    logic [5:0] p;

    rst_n = 1'b0; ready = 1'b1; tvalue_in = '0; clear_ovf = 1'b0;
    tick(3);
    check("reset_valid", 8'(valid), 8'd0);
    check("reset_now", 8'(nowCount), 8'd0);
    check("reset_ovf", 8'(overflow), 8'd0);
    rst_n = 1'b1;
    tick(D + 4);

    // single pattern, latency DEBOUNCE+3
    base = xfers;
    exp_q.push_back(3'd2);
    tvalue_in = 6'b000100;
    tick(7);
    check("lat_edge6_valid", 8'(valid), 8'd0);
    tick(1);
    check("lat_edge7_valid", 8'(valid), 8'd1);
    check("lat_edge7_now", 8'(nowCount), 8'd2);
    tick(3);
    check("single_valid_low", 8'(valid), 8'd0);
    check("single_xfers", 8'(xfers - base), 8'd1);
    hold(6'b000000, 10);
    check("release_no_xfer", 8'(xfers - base), 8'd1);

    // glitch shorter than DEBOUNCE
    hold(6'b010000, 3);
    hold(6'b000000, 12);
    check("glitch_no_xfer", 8'(xfers - base), 8'd1);
    check("glitch_valid", 8'(valid), 8'd0);

    // ordered sequence including all-on and invalid patterns
    base = xfers;
    exp_q.push_back(3'd0); exp_q.push_back(3'd6); exp_q.push_back(3'd7);
    hold(6'b000001, 10);
    hold(6'b111111, 10);
    hold(6'b000011, 10);
    tick(4);
    check("seq_xfers", 8'(xfers - base), 8'd3);
    check("seq_q_empty", 8'(exp_q.size()), 8'd0);

    // stall with three events: middle one is lost
    ready = 1'b0;
    exp_q.push_back(3'd1); exp_q.push_back(3'd5);
    hold(6'b000010, 10);
    hold(6'b001000, 10);
    hold(6'b100000, 10);
    check("stall_now", 8'(nowCount), 8'd1);
    check("stall_valid", 8'(valid), 8'd1);
    check("stall_ovf", 8'(overflow), 8'd1);
    ready = 1'b1;
    tick(1);
    check("drain1_now", 8'(nowCount), 8'd5);
    check("drain1_valid", 8'(valid), 8'd1);
    tick(1);
    check("drain2_valid", 8'(valid), 8'd0);
    check("ovf_sticky", 8'(overflow), 8'd1);
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    check("ovf_cleared", 8'(overflow), 8'd0);

    // accept and event on the same edge, pending empty
    ready = 1'b0;
    exp_q.push_back(3'd0);
    hold(6'b000001, 10);
    check("same_pre_now", 8'(nowCount), 8'd0);
    exp_q.push_back(3'd1);
    tvalue_in = 6'b000010;
    tick(7);
    check("same_e6_valid", 8'(valid), 8'd1);
    check("same_e6_now", 8'(nowCount), 8'd0);
    ready = 1'b1;
    tick(1);
    check("same_e7_valid", 8'(valid), 8'd1);
    check("same_e7_now", 8'(nowCount), 8'd1);
    check("same_e7_ovf", 8'(overflow), 8'd0);
    tick(1);
    check("same_e8_valid", 8'(valid), 8'd0);

    // reset with output and pending full, mid-debounce
    ready = 1'b0;
    hold(6'b000100, 10);
    hold(6'b001000, 10);
    tvalue_in = 6'b010000;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check("midrst_valid", 8'(valid), 8'd0);
    check("midrst_ovf", 8'(overflow), 8'd0);
    check("midrst_now", 8'(nowCount), 8'd0);
    rst_n = 1'b1;
    ready = 1'b1;
    base = xfers;
    exp_q.push_back(3'd5);
    hold(6'b100000, D + 10);
    check("post_rst_xfers", 8'(xfers - base), 8'd1);
    check("post_rst_q_empty", 8'(exp_q.size()), 8'd0);

    // randomized holds and glitches with bounded stalls
    last_acc = 6'b100000;
    held = last_acc;
    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        p = 6'($urandom_range(0, 63));
        hold(p, $urandom_range(1, D - 1));
        hold(held, D + 4);
      end else begin
        p = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 2) == 0) p = 6'(1) << $urandom_range(0, 5);
        held = p;
        if (p != last_acc) begin
          last_acc = p;
          if (p != 6'd0) exp_q.push_back(ref_index(p));
        end
        hold(p, $urandom_range(D + 4, D + 12));
      end
    end
    rnd_ready = 1'b0;
    ready = 1'b1;
    tick(10);
    check("rand_q_empty", 8'(exp_q.size()), 8'd0);
    check("rand_valid_idle", 8'(valid), 8'd0);
    check("rand_no_ovf", 8'(overflow), 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
